// File: rtl/iq_mic_assembler.sv
// rtl/iq_mic_assembler.sv - double-buffered IQ/mic sample set assembler feeding the Tx frame builder
//
// Gathers one 48-bit IQ sample per receiver (channels 0..IF_max_chan) plus the
// latest microphone sample into a capture bank. A complete set is promoted into
// a hold bank and offered to the consumer through Tx_IQ_mic_rdy / Tx_IQ_mic_ack.
//
// Ports:
//   IF_clk, IF_reset       clock, asynchronous active-high reset
//   IF_max_chan            highest receiver index in use
//   IQ_in_valid/chan/data  IQ sample strobe, receiver index, {I,Q}
//   mic_valid/mic_data     microphone sample strobe and value
//   IF_chan                hold slot selected for Tx_IQ_mic_data
//   Tx_IQ_mic_ack          consumer handshake level
//   Tx_IQ_mic_rdy          hold bank has an unconsumed complete set
//   Tx_IQ_mic_data         {hold_iq[IF_chan], hold_mic}, combinational
//   overrun_cnt            saturating count of dropped IQ samples
`timescale 1ns/1ps

module iq_mic_assembler #(
  parameter int NUM_CHAN = 8
) (
  input  logic        IF_clk,
  input  logic        IF_reset,
  input  logic [2:0]  IF_max_chan,
  input  logic        IQ_in_valid,
  input  logic [2:0]  IQ_in_chan,
  input  logic [47:0] IQ_in_data,
  input  logic        mic_valid,
  input  logic [15:0] mic_data,
  input  logic [2:0]  IF_chan,
  input  logic        Tx_IQ_mic_ack,
  output logic        Tx_IQ_mic_rdy,
  output logic [63:0] Tx_IQ_mic_data,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_READY = 2'd1,
    H_ACKED = 2'd2
  } hold_state_t;

  hold_state_t         state_q, state_d;

  logic [47:0]         cap_q  [NUM_CHAN];
  logic [47:0]         hold_q [NUM_CHAN];
  logic [NUM_CHAN-1:0] cap_mask_q, cap_mask_d;
  logic [15:0]         mic_latch_q;
  logic [15:0]         hold_mic_q;
  logic [2:0]          max_q;
  logic [7:0]          ovr_q;

  logic [NUM_CHAN-1:0] in_use;
  logic                set_complete;
  logic                max_chg;
  logic                promote;
  logic                iq_in_range;
  logic                iq_drop;
  logic                iq_write;

  // Channels 0..IF_max_chan take part in the set; unused slots count as filled.
  always_comb begin
    in_use = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (i <= int'(IF_max_chan)) in_use[i] = 1'b1;
    end
  end

  assign set_complete = &(cap_mask_q | ~in_use);
  assign max_chg      = (IF_max_chan != max_q);
  assign iq_in_range  = IQ_in_valid && (IQ_in_chan <= IF_max_chan);

  // A sample is dropped only when the capture bank is full and stuck behind an
  // occupied hold bank. On a promotion or channel-count change the bank is being
  // emptied this very edge, so the sample goes into the fresh bank instead.
  assign iq_drop  = iq_in_range && cap_mask_q[IQ_in_chan] && set_complete &&
                    !promote && !max_chg;
  assign iq_write = iq_in_range && !iq_drop;

  // Mask clear first, then the incoming sample's bit, so a sample arriving on a
  // clearing edge survives as the first member of the next set.
  always_comb begin
    cap_mask_d = cap_mask_q;
    if (promote || max_chg) cap_mask_d = '0;
    if (iq_write) cap_mask_d[IQ_in_chan] = 1'b1;
  end

  // Hold FSM: state register
  always_ff @(posedge IF_clk or posedge IF_reset) begin
    if (IF_reset) state_q <= H_EMPTY;
    else          state_q <= state_d;
  end

  // Hold FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      H_EMPTY: if (promote)        state_d = H_READY;
      H_READY: if (Tx_IQ_mic_ack)  state_d = H_ACKED;
      H_ACKED: if (!Tx_IQ_mic_ack) state_d = H_EMPTY;
      default:                     state_d = H_EMPTY;
    endcase
  end

  // Hold FSM: outputs. Promotion is held off on a channel-count change because
  // the mask is being discarded that edge.
  always_comb begin
    Tx_IQ_mic_rdy = 1'b0;
    promote       = 1'b0;
    case (state_q)
      H_EMPTY: promote       = set_complete && !max_chg;
      H_READY: Tx_IQ_mic_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge IF_clk or posedge IF_reset) begin
    if (IF_reset) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        cap_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      cap_mask_q  <= '0;
      mic_latch_q <= '0;
      hold_mic_q  <= '0;
      max_q       <= '0;
      ovr_q       <= '0;
    end else begin
      max_q      <= IF_max_chan;
      cap_mask_q <= cap_mask_d;
      if (iq_write) cap_q[IQ_in_chan] <= IQ_in_data;
      if (mic_valid) mic_latch_q <= mic_data;
      // Non-blocking copy: hold_mic takes the mic value from before this edge.
      if (promote) begin
        for (int i = 0; i < NUM_CHAN; i++) hold_q[i] <= cap_q[i];
        hold_mic_q <= mic_latch_q;
      end
      if (iq_drop && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
    end
  end

  always_comb begin
    if (IF_chan <= IF_max_chan) Tx_IQ_mic_data = {hold_q[IF_chan], hold_mic_q};
    else                        Tx_IQ_mic_data = {48'h0, hold_mic_q};
  end

  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_iq_mic_assembler.sv
// tb/tb_iq_mic_assembler.sv - self-checking bench for iq_mic_assembler
`timescale 1ns/1ps

module tb_iq_mic_assembler;

  logic        IF_clk;
  logic        IF_reset;
  logic [2:0]  IF_max_chan;
  logic        IQ_in_valid;
  logic [2:0]  IQ_in_chan;
  logic [47:0] IQ_in_data;
  logic        mic_valid;
  logic [15:0] mic_data;
  logic [2:0]  IF_chan;
  logic        Tx_IQ_mic_ack;
  logic        Tx_IQ_mic_rdy;
  logic [63:0] Tx_IQ_mic_data;
  logic [7:0]  overrun_cnt;

  iq_mic_assembler #(.NUM_CHAN(8)) dut (
    .IF_clk         (IF_clk),
    .IF_reset       (IF_reset),
    .IF_max_chan    (IF_max_chan),
    .IQ_in_valid    (IQ_in_valid),
    .IQ_in_chan     (IQ_in_chan),
    .IQ_in_data     (IQ_in_data),
    .mic_valid      (mic_valid),
    .mic_data       (mic_data),
    .IF_chan        (IF_chan),
    .Tx_IQ_mic_ack  (Tx_IQ_mic_ack),
    .Tx_IQ_mic_rdy  (Tx_IQ_mic_rdy),
    .Tx_IQ_mic_data (Tx_IQ_mic_data),
    .overrun_cnt    (overrun_cnt)
  );

  initial IF_clk = 1'b0;
  always #5 IF_clk = ~IF_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  max;
    int          n;
    logic [2:0]  order [8];
    logic [47:0] iq    [8];
    logic [15:0] mic;
    logic [63:0] exp_ch7;
  } set_vec_t;

  set_vec_t    vecs [4];
  logic [63:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge IF_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] ch, input logic [47:0] d);
    IQ_in_valid = 1'b1;
    IQ_in_chan  = ch;
    IQ_in_data  = d;
    step();
    IQ_in_valid = 1'b0;
  endtask

  task automatic send_mic(input logic [15:0] m);
    mic_valid = 1'b1;
    mic_data  = m;
    step();
    mic_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ch, input string name, input logic [63:0] exp);
    IF_chan = ch;
    @(negedge IF_clk);
    check(name, Tx_IQ_mic_data, exp);
  endtask

  task automatic do_ack();
    Tx_IQ_mic_ack = 1'b1;
    step();
    Tx_IQ_mic_ack = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] e;

    vecs[0].max = 3'd2; vecs[0].n = 3; vecs[0].mic = 16'h1357;
    vecs[0].order[0] = 3'd2; vecs[0].order[1] = 3'd0; vecs[0].order[2] = 3'd1;
    vecs[1].max = 3'd7; vecs[1].n = 8; vecs[1].mic = 16'hBEEF;
    vecs[1].order[0] = 3'd5; vecs[1].order[1] = 3'd3; vecs[1].order[2] = 3'd7; vecs[1].order[3] = 3'd0;
    vecs[1].order[4] = 3'd6; vecs[1].order[5] = 3'd1; vecs[1].order[6] = 3'd4; vecs[1].order[7] = 3'd2;
    vecs[2].max = 3'd3; vecs[2].n = 4; vecs[2].mic = 16'h0F0F;
    vecs[2].order[0] = 3'd3; vecs[2].order[1] = 3'd2; vecs[2].order[2] = 3'd1; vecs[2].order[3] = 3'd0;
    vecs[3].max = 3'd0; vecs[3].n = 1; vecs[3].mic = 16'hA5A5;
    vecs[3].order[0] = 3'd0;
    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < 8; c++) vecs[v].iq[c] = {8'(v), 8'(c), 32'($urandom)};
      vecs[v].exp_ch7 = (vecs[v].max == 3'd7) ? {vecs[v].iq[7], vecs[v].mic} : {48'h0, vecs[v].mic};
    end

    IF_reset = 1'b1; IF_max_chan = 3'd0; IQ_in_valid = 1'b0; IQ_in_chan = 3'd0;
    IQ_in_data = '0; mic_valid = 1'b0; mic_data = '0; IF_chan = 3'd0; Tx_IQ_mic_ack = 1'b0;
    step(); step();
    IF_reset = 1'b0;
    step();
    check("reset_rdy", 64'(Tx_IQ_mic_rdy), 64'd0);
    check("reset_data", Tx_IQ_mic_data, 64'h0);
    check("reset_ovr", 64'(overrun_cnt), 64'd0);

    // Table-driven sets with scoreboard readback
    for (int v = 0; v < 4; v++) begin
      IF_max_chan = vecs[v].max;
      step();
      send_mic(vecs[v].mic);
      for (int k = 0; k < vecs[v].n; k++) begin
        send(vecs[v].order[k], vecs[v].iq[vecs[v].order[k]]);
        if (k < vecs[v].n - 1) check($sformatf("v%0d_rdy_early_k%0d", v, k), 64'(Tx_IQ_mic_rdy), 64'd0);
      end
      for (int c = 0; c <= int'(vecs[v].max); c++) sb_q.push_back({vecs[v].iq[c], vecs[v].mic});
      check($sformatf("v%0d_rdy_same_cycle", v), 64'(Tx_IQ_mic_rdy), 64'd0);
      step();
      check($sformatf("v%0d_rdy_latency", v), 64'(Tx_IQ_mic_rdy), 64'd1);
      for (int c = 0; c <= int'(vecs[v].max); c++) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD;
        rd(3'(c), $sformatf("v%0d_data_ch%0d", v, c), e);
      end
      rd(3'd7, $sformatf("v%0d_data_ch7", v), vecs[v].exp_ch7);
      IF_chan = 3'd0;
      step();
      do_ack();
      check($sformatf("v%0d_rdy_after_ack", v), 64'(Tx_IQ_mic_rdy), 64'd0);
    end

    // Sample in promotion cycle; out-of-range channel ignored
    IF_max_chan = 3'd1;
    step();
    send_mic(16'hB00B);
    send(3'd0, 48'h000000_0000A0);
    send(3'd1, 48'h000000_0000A1);
    send(3'd0, 48'h000000_0000B0);
    check("bnd_rdy", 64'(Tx_IQ_mic_rdy), 64'd1);
    rd(3'd0, "bnd_hold_ch0", {48'h000000_0000A0, 16'hB00B});
    rd(3'd1, "bnd_hold_ch1", {48'h000000_0000A1, 16'hB00B});
    send(3'd7, 48'h777777_777777);
    send(3'd1, 48'h000000_0000B1);
    send(3'd7, 48'h777777_777778);
    check("bnd_ch7_no_count", 64'(overrun_cnt), 64'd0);
    do_ack();
    step();
    check("bnd_next_rdy", 64'(Tx_IQ_mic_rdy), 64'd1);
    rd(3'd0, "bnd_next_ch0", {48'h000000_0000B0, 16'hB00B});
    rd(3'd1, "bnd_next_ch1", {48'h000000_0000B1, 16'hB00B});
    IF_chan = 3'd0;
    step();
    do_ack();

    // IF_max_chan change discards a partial set
    send(3'd0, 48'h000000_0000C0);
    IF_max_chan = 3'd3;
    step();
    send(3'd1, 48'h000000_0000C1);
    send(3'd2, 48'h000000_0000C2);
    send(3'd3, 48'h000000_0000C3);
    step();
    check("maxchg_no_rdy", 64'(Tx_IQ_mic_rdy), 64'd0);
    send(3'd0, 48'h000000_0000D0);
    step();
    check("maxchg_rdy", 64'(Tx_IQ_mic_rdy), 64'd1);
    rd(3'd0, "maxchg_ch0", {48'h000000_0000D0, 16'hB00B});
    rd(3'd3, "maxchg_ch3", {48'h000000_0000C3, 16'hB00B});
    IF_chan = 3'd0;
    step();
    do_ack();

    // Single-channel set and ack timing
    IF_max_chan = 3'd0;
    step();
    send_mic(16'h55AA);
    send(3'd0, 48'h123456_ABCDEF);
    check("m0_rdy_same_cycle", 64'(Tx_IQ_mic_rdy), 64'd0);
    step();
    check("m0_rdy", 64'(Tx_IQ_mic_rdy), 64'd1);
    check("m0_data", Tx_IQ_mic_data, 64'h123456ABCDEF55AA);
    send(3'd0, 48'h111111_222222);
    Tx_IQ_mic_ack = 1'b1;
    step();
    check("ack_rdy_low", 64'(Tx_IQ_mic_rdy), 64'd0);
    check("ack_data_stable", Tx_IQ_mic_data, 64'h123456ABCDEF55AA);
    step(); step();
    Tx_IQ_mic_ack = 1'b0;
    step();
    check("release_rdy_still_low", 64'(Tx_IQ_mic_rdy), 64'd0);
    step();
    check("release_rdy_rise", 64'(Tx_IQ_mic_rdy), 64'd1);
    check("release_data", Tx_IQ_mic_data, 64'h111111222222_55AA);

    // Overrun counting and saturation
    send(3'd0, 48'hAAAAAA_AAAAAA);
    send(3'd0, 48'h000000_000001);
    send(3'd0, 48'h000000_000002);
    send(3'd0, 48'h000000_000003);
    check("ovr_3", 64'(overrun_cnt), 64'd3);
    do_ack();
    step();
    check("ovr_rdy", 64'(Tx_IQ_mic_rdy), 64'd1);
    check("ovr_capture_kept", Tx_IQ_mic_data, 64'hAAAAAAAAAAAA_55AA);
    send(3'd0, 48'hBBBBBB_BBBBBB);
    for (int k = 0; k < 300; k++) send(3'd0, 48'($urandom));
    check("ovr_sat", 64'(overrun_cnt), 64'd255);
    check("ovr_hold_stable", Tx_IQ_mic_data, 64'hAAAAAAAAAAAA_55AA);

    // Async reset while rdy is high
    IF_reset = 1'b1;
    #1;
    check("async_rst_rdy", 64'(Tx_IQ_mic_rdy), 64'd0);
    check("async_rst_data", Tx_IQ_mic_data, 64'h0);
    step();
    IF_reset = 1'b0;
    step();
    check("post_rst_ovr", 64'(overrun_cnt), 64'd0);
    check("post_rst_rdy", 64'(Tx_IQ_mic_rdy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
